// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues IM reads on credit, buffers {pc, inst} for decode.
// Optional FETCHQ_BYPASS_EN: an empty queue forwards the arriving IM response straight to the if_* outputs.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_true,
    input  logic [ADDR_W-1:0] new_addr,
    output logic              IM_read,
    output logic [ADDR_W-1:0] IM_addr,
    input  logic [DATA_W-1:0] IM_out,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    input  logic              id_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] last_pc;
    logic [DATA_W-1:0] last_inst;
    logic              resp_pending;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credit_used;
    logic              fifo_empty;
    logic              resp_ok;
    logic              bypass_hit;
    logic              pop;
    logic              fifo_pop;
    logic              push;

    // An in-flight response already owns a slot, so it counts against the credit.
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, resp_pending};
    assign IM_read     = !rst && !branch_true && (credit_used < (CNT_W + 1)'(DEPTH));
    assign IM_addr     = fetch_pc;
    assign fifo_empty  = (count == '0);
    assign resp_ok     = resp_pending && !branch_true;

`ifdef FETCHQ_BYPASS_EN
    assign bypass_hit = fifo_empty && resp_ok;
`else
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        if_valid = !fifo_empty;
        if_pc    = fifo_empty ? last_pc   : pc_mem[rd_ptr];
        if_inst  = fifo_empty ? last_inst : inst_mem[rd_ptr];
        if (bypass_hit) begin
            if_valid = 1'b1;
            if_pc    = resp_pc;
            if_inst  = IM_out;
        end
    end

    assign pop      = if_valid && id_ready;
    assign fifo_pop = pop && !fifo_empty;
    assign push     = resp_ok && !(bypass_hit && id_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            inst_mem[wr_ptr] <= IM_out;
        end
    end

    // A taken branch discards everything queued or in flight and restarts fetch at the target.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc     <= '0;
            resp_pc      <= '0;
            resp_pending <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            last_pc      <= '0;
            last_inst    <= '0;
        end else begin
            assert (!(push && count == CNT_W'(DEPTH)));
            if (pop) begin
                last_pc   <= if_pc;
                last_inst <= if_inst;
            end
            if (branch_true) begin
                fetch_pc     <= new_addr;
                resp_pending <= 1'b0;
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                count        <= '0;
            end else begin
                resp_pending <= IM_read;
                if (IM_read) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                    resp_pc  <= fetch_pc;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (fifo_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, fifo_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: streaming, backpressure, flush, in-flight flush, PC wrap.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        branch_true;
    logic [31:0] new_addr;
    logic        IM_read;
    logic [31:0] IM_addr;
    logic [31:0] IM_out;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;

    int passed = 0;
    int failed = 0;
    int total  = 0;

`ifdef FETCHQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .branch_true (branch_true),
        .new_addr    (new_addr),
        .IM_read     (IM_read),
        .IM_addr     (IM_addr),
        .IM_out      (IM_out),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .id_ready    (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    // Instruction memory with one cycle of read latency.
    initial IM_out = '0;
    always @(posedge clk) begin
        if (IM_read) IM_out <= im_word(IM_addr);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic apply_stimulus(input logic r, input logic br, input logic [31:0] na, input logic rdy);
        rst         = r;
        branch_true = br;
        new_addr    = na;
        id_ready    = rdy;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called in cycle N+1 after a redirect with id_ready held high.
    task automatic check_redirect(input string tag, input logic [31:0] target, input int last_k);
        logic [31:0] exp_pc;
        for (int k = 1; k <= last_k; k++) begin
            if (k > 1) tick();
            check_output({tag, "_valid"}, {31'd0, if_valid}, {31'd0, (k > LAT)});
            if (k > LAT) begin
                exp_pc = target + 32'(4 * (k - LAT - 1));
                check_output({tag, "_pc"}, if_pc, exp_pc);
                check_output({tag, "_inst"}, if_inst, im_word(exp_pc));
            end
        end
    endtask

    initial begin
        logic [31:0] exp_pc;

        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        check_output("rst_im_read", {31'd0, IM_read}, 32'd0);
        check_output("rst_im_addr", IM_addr, 32'd0);
        check_output("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check_output("rst_if_pc", if_pc, 32'd0);
        check_output("rst_if_inst", if_inst, 32'd0);

        apply_stimulus(1'b1, 1'b1, 32'h200, 1'b1);
        check_output("prio_im_read", {31'd0, IM_read}, 32'd0);
        tick();
        check_output("prio_im_addr", IM_addr, 32'd0);

        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        check_output("c0_im_read", {31'd0, IM_read}, 32'd1);
        check_output("c0_im_addr", IM_addr, 32'd0);
        check_output("c0_if_valid", {31'd0, if_valid}, 32'd0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            check_output("stream_im_addr", IM_addr, 32'(4 * k));
            check_output("stream_valid", {31'd0, if_valid}, {31'd0, (k >= LAT)});
            if (k >= LAT) begin
                exp_pc = 32'(4 * (k - LAT));
                check_output("stream_pc", if_pc, exp_pc);
                check_output("stream_inst", if_inst, im_word(exp_pc));
            end
        end

        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) tick();
        check_output("bp_count", 32'(dut.count), 32'd4);
        check_output("bp_im_read", {31'd0, IM_read}, 32'd0);
        check_output("bp_valid", {31'd0, if_valid}, 32'd1);
        check_output("bp_head_pc", if_pc, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        check_output("bp_first_pop_im_read", {31'd0, IM_read}, 32'd0);
        for (int j = 0; j <= 5; j++) begin
            if (j > 0) tick();
            check_output("drain_valid", {31'd0, if_valid}, 32'd1);
            check_output("drain_pc", if_pc, 32'(4 * j));
            check_output("drain_inst", if_inst, im_word(32'(4 * j)));
            if (j == 1) begin
                check_output("resume_im_read", {31'd0, IM_read}, 32'd1);
                check_output("resume_im_addr", IM_addr, 32'd16);
            end
        end

        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) tick();
        check_output("full_head_pc", if_pc, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'h40, 1'b0);
        check_output("flush_im_read", {31'd0, IM_read}, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        check_output("flush_redirect_read", {31'd0, IM_read}, 32'd1);
        check_output("flush_redirect_addr", IM_addr, 32'h40);
        check_redirect("flush", 32'h40, LAT + 2);

        tick();
        apply_stimulus(1'b0, 1'b1, 32'h100, 1'b1);
        check_output("inflight_pending", {31'd0, dut.resp_pending}, 32'd1);
        check_output("inflight_im_read", {31'd0, IM_read}, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        check_redirect("inflight", 32'h100, LAT + 2);

        tick();
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        check_redirect("wrap", 32'hFFFF_FFF8, LAT + 3);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
